// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, one-hot write
// enables, FSM state encoding and small decode helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_WORD = 3'b001;
  localparam logic [2:0] WE_HALF = 3'b010;
  localparam logic [2:0] WE_BYTE = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } lsu_state_e;

  // The low two funct3 bits encode the access size for both loads and stores.
  function automatic logic [2:0] weCode(input logic [1:0] size);
    case (size)
      2'b00:   weCode = WE_BYTE;
      2'b01:   weCode = WE_HALF;
      2'b10:   weCode = WE_WORD;
      default: weCode = WE_NONE;
    endcase
  endfunction

  function automatic logic isIllegal(input logic [2:0] funct3, input logic write);
    isIllegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                (write && funct3[2]);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational sign/zero extension of load data that memory has already
// shifted down to bit 0.
module load_extend
  import mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_funct3)
      F3_B:    o_data = {{24{i_data[7]}}, i_data[7:0]};
      F3_BU:   o_data = {24'd0, i_data[7:0]};
      F3_H:    o_data = {{16{i_data[15]}}, i_data[15:0]};
      F3_HU:   o_data = {16'd0, i_data[15:0]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: single outstanding access, IDLE/ACCESS/WAIT/RESP FSM.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [2:0]  mem_write_enable,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  // WAIT holds MEM_LATENCY-1 cycles; the counter reloads with that count minus one.
  localparam logic [1:0] WAIT_INIT = (MEM_LATENCY > 2) ? 2'(MEM_LATENCY - 2) : 2'd0;

  lsu_state_e  r_state;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_waitCnt;
  logic [2:0]  r_memWe;
  logic        r_respValid;
  logic        r_respErr;

  logic        w_misalign;
  logic        w_illegal;
  logic [31:0] w_extData;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_illegal = isIllegal(req_funct3, req_write) || w_misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_write     <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_waitCnt   <= 2'd0;
      r_memWe     <= WE_NONE;
      r_respValid <= 1'b0;
      r_respErr   <= 1'b0;
    end else begin
      r_memWe     <= WE_NONE;
      r_respValid <= 1'b0;
      r_respErr   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            if (w_illegal) begin
              r_state     <= RESP;
              r_respValid <= 1'b1;
              r_respErr   <= 1'b1;
            end else begin
              r_state <= ACCESS;
              if (req_write) r_memWe <= weCode(req_funct3[1:0]);
            end
          end
        end
        ACCESS: begin
          if (r_write || (MEM_LATENCY <= 1)) begin
            r_state     <= RESP;
            r_respValid <= 1'b1;
          end else begin
            r_state   <= WAIT;
            r_waitCnt <= WAIT_INIT;
          end
        end
        WAIT: begin
          if (r_waitCnt == 2'd0) begin
            r_state     <= RESP;
            r_respValid <= 1'b1;
          end else begin
            r_waitCnt <= r_waitCnt - 2'd1;
          end
        end
        RESP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  load_extend u_load_extend (
    .i_funct3 (r_funct3),
    .i_data   (mem_data_out),
    .o_data   (w_extData)
  );

  assign req_ready        = (r_state == IDLE) && !rst;
  assign resp_valid       = r_respValid;
  assign resp_err         = r_respErr;
  assign resp_rdata       = (r_state == RESP && !r_write && !r_respErr) ? w_extData : 32'd0;
  assign mem_write_enable = r_memWe;
  assign mem_addr         = r_addr;
  assign mem_data_in      = r_wdata;

endmodule
